// File: rtl/apb_ucpd_tx_sched.sv
// apb_ucpd_tx_sched
// Schedules UCPD transmissions: latches SW message / Hard Reset requests,
// waits out the interframe gap on an idle bus, opens a one-cycle transmit
// window and then holds the transmit level until the TX FSM reports done.
// A watchdog bounds the time spent transmitting.
//
// Ports
//   ic_clk, ic_rst_n          clock, async active-low reset
//   ucpden                    peripheral enable, low = synchronous clear
//   txsend_req, txhrst_req    one-cycle SW requests (message / Hard Reset)
//   rx_idle, rx_active        receiver status: bus free / preamble seen
//   tx_done                   one-cycle pulse from the TX FSM on completion
//   ifrgap_cfg, tmo_cfg       gap length and watchdog limit (0 = off)
//   transwin_en, transmit_en, tx_hrst, tx_busy   registered levels
//   msg_sent, hrst_sent, msg_disc, req_drop, tx_tmo   registered pulses
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight, waiting for a pending flag
// GAP      | counting idle-bus cycles before the transmit window
// GRANT    | one-cycle transmit window, picks message or Hard Reset
// ACT_MSG  | message on the wire (may be aborted by a Hard Reset)
// ACT_HRST | Hard Reset on the wire
module apb_ucpd_tx_sched #(
    parameter int GAP_W = 9,
    parameter int TMO_W = 16
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             ucpden,
    input  logic             txsend_req,
    input  logic             txhrst_req,
    input  logic             rx_idle,
    input  logic             rx_active,
    input  logic             tx_done,
    input  logic [GAP_W-1:0] ifrgap_cfg,
    input  logic [TMO_W-1:0] tmo_cfg,
    output logic             transwin_en,
    output logic             transmit_en,
    output logic             tx_hrst,
    output logic             tx_busy,
    output logic             msg_sent,
    output logic             hrst_sent,
    output logic             msg_disc,
    output logic             req_drop,
    output logic             tx_tmo
);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_GRANT, S_ACT_MSG, S_ACT_HRST
    } state_t;

    state_t           state_q, state_d;
    logic             msg_pend_q, msg_pend_d;
    logic             hrst_pend_q, hrst_pend_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [8:0]       outs_q, outs_d;
    logic             msg_sent_d, hrst_sent_d, msg_disc_d, req_drop_d, tx_tmo_d;
    logic             tmo_hit, act_d;

    assign tmo_hit = (tmo_cfg != '0) && (tmo_cnt_q == tmo_cfg);

    always_comb begin
        state_d     = state_q;
        msg_pend_d  = msg_pend_q;
        hrst_pend_d = hrst_pend_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = '0;
        msg_sent_d  = 1'b0;
        hrst_sent_d = 1'b0;
        msg_disc_d  = 1'b0;
        req_drop_d  = 1'b0;
        tx_tmo_d    = 1'b0;
        act_d       = 1'b0;
        outs_d      = '0;

        // Requests. A simultaneous message request loses to the Hard Reset.
        if (txhrst_req) begin
            if (hrst_pend_q) req_drop_d  = 1'b1;
            else             hrst_pend_d = 1'b1;
        end
        if (txsend_req) begin
            if (txhrst_req)
                msg_disc_d = 1'b1;
            else if (msg_pend_q || state_q == S_ACT_HRST)
                req_drop_d = 1'b1;
            else
                msg_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (msg_pend_q || hrst_pend_q) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                // A colliding preamble only cancels a plain message.
                if (rx_active && msg_pend_q && !hrst_pend_q) begin
                    msg_pend_d = 1'b0;
                    msg_disc_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (rx_idle) begin
                    if (gap_cnt_q == ifrgap_cfg)
                        state_d = S_GRANT;
                    else if (gap_cnt_q != '1)
                        gap_cnt_d = gap_cnt_q + 1'b1;
                end else begin
                    gap_cnt_d = '0;
                end
            end
            S_GRANT: begin
                state_d = hrst_pend_q ? S_ACT_HRST : S_ACT_MSG;
            end
            S_ACT_MSG: begin
                if (tx_done) begin
                    // Done with a Hard Reset pending means the message was aborted.
                    msg_pend_d = 1'b0;
                    if (hrst_pend_q) msg_disc_d = 1'b1;
                    else             msg_sent_d = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    msg_pend_d  = 1'b0;
                    hrst_pend_d = 1'b0;
                    tx_tmo_d    = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_ACT_HRST: begin
                if (tx_done) begin
                    hrst_pend_d = 1'b0;
                    hrst_sent_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (tmo_hit) begin
                    msg_pend_d  = 1'b0;
                    hrst_pend_d = 1'b0;
                    tx_tmo_d    = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter value = number of cycles spent in the active state so far.
        if (state_d == S_ACT_MSG || state_d == S_ACT_HRST)
            tmo_cnt_d = (state_q == state_d && tmo_cnt_q != '1) ? tmo_cnt_q + 1'b1
                      : (state_q == state_d) ? tmo_cnt_q : TMO_W'(1);

        if (!ucpden) begin
            state_d     = S_IDLE;
            msg_pend_d  = 1'b0;
            hrst_pend_d = 1'b0;
            gap_cnt_d   = '0;
            tmo_cnt_d   = '0;
            msg_sent_d  = 1'b0;
            hrst_sent_d = 1'b0;
            msg_disc_d  = 1'b0;
            req_drop_d  = 1'b0;
            tx_tmo_d    = 1'b0;
        end

        // Levels are derived from the next state so they line up with state_q.
        act_d = (state_d == S_GRANT) || (state_d == S_ACT_MSG) || (state_d == S_ACT_HRST);
        outs_d = {
            state_d == S_GRANT,
            act_d && !hrst_pend_d && state_d != S_ACT_HRST,
            act_d && hrst_pend_d,
            state_d != S_IDLE,
            msg_sent_d, hrst_sent_d, msg_disc_d, req_drop_d, tx_tmo_d
        };
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q     <= S_IDLE;
            msg_pend_q  <= 1'b0;
            hrst_pend_q <= 1'b0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            outs_q      <= '0;
        end else begin
            state_q     <= state_d;
            msg_pend_q  <= msg_pend_d;
            hrst_pend_q <= hrst_pend_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            outs_q      <= outs_d;
        end
    end

    assign {transwin_en, transmit_en, tx_hrst, tx_busy,
            msg_sent, hrst_sent, msg_disc, req_drop, tx_tmo} = outs_q;

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
module tb_apb_ucpd_tx_sched;

    logic       ic_clk = 1'b0;
    logic       ic_rst_n = 1'b0;
    logic       ucpden = 1'b1;
    logic       txsend_req = 1'b0;
    logic       txhrst_req = 1'b0;
    logic       rx_idle = 1'b1;
    logic       rx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic [8:0] ifrgap_cfg = 9'd4;
    logic [15:0] tmo_cfg = 16'd0;
    logic transwin_en, transmit_en, tx_hrst, tx_busy;
    logic msg_sent, hrst_sent, msg_disc, req_drop, tx_tmo;
    logic [8:0] outs;

    int n_checks = 0;
    int n_fail = 0;

    apb_ucpd_tx_sched #(.GAP_W(9), .TMO_W(16)) dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
        .txsend_req(txsend_req), .txhrst_req(txhrst_req),
        .rx_idle(rx_idle), .rx_active(rx_active), .tx_done(tx_done),
        .ifrgap_cfg(ifrgap_cfg), .tmo_cfg(tmo_cfg),
        .transwin_en(transwin_en), .transmit_en(transmit_en), .tx_hrst(tx_hrst),
        .tx_busy(tx_busy), .msg_sent(msg_sent), .hrst_sent(hrst_sent),
        .msg_disc(msg_disc), .req_drop(req_drop), .tx_tmo(tx_tmo)
    );

    assign outs = {transwin_en, transmit_en, tx_hrst, tx_busy,
                   msg_sent, hrst_sent, msg_disc, req_drop, tx_tmo};

    always #5 ic_clk = ~ic_clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge ic_clk);
    endtask

    // Runs until the transmit window opens; counts busy cycles before it.
    task automatic wait_grant(output int gaps, output bit ok);
        gaps = 0;
        ok = 1'b0;
        for (int g = 0; g < 100; g++) begin
            tick();
            if (transwin_en) begin
                ok = 1'b1;
                break;
            end
            if (tx_busy) gaps++;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL reset_outs: got %b want %b", outs, 9'b0);
        end
        ic_rst_n = 1'b1;
        tick();
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want %b", outs, 9'b0);
        end
    endtask

    task automatic test_normal_msg();
        int gaps; bit ok; bit bad;
        ifrgap_cfg = 9'd4;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        n_checks++;
        if (tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL norm_busy_after_req: got %b want 0", tx_busy);
        end
        wait_grant(gaps, ok);
        n_checks++;
        if (!ok || gaps != 5) begin
            n_fail++; $display("FAIL norm_gap_cycles: got %0d (ok=%0b) want 5", gaps, ok);
        end
        n_checks++;
        if ({transwin_en, transmit_en, tx_hrst} !== 3'b110) begin
            n_fail++; $display("FAIL norm_grant: got %b want 110", {transwin_en, transmit_en, tx_hrst});
        end
        tick();
        n_checks++;
        if ({transwin_en, transmit_en, tx_busy} !== 3'b011) begin
            n_fail++; $display("FAIL norm_act: got %b want 011", {transwin_en, transmit_en, tx_busy});
        end
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        n_checks++;
        if ({req_drop, transmit_en} !== 2'b11) begin
            n_fail++; $display("FAIL norm_drop_in_act: got %b want 11", {req_drop, transmit_en});
        end
        bad = 1'b0;
        repeat (18) begin
            tick();
            if (outs !== 9'b010100000) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL norm_hold: got %b want 010100000", outs);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if (outs !== 9'b000010000) begin
            n_fail++; $display("FAIL norm_sent: got %b want 000010000", outs);
        end
        tick();
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL norm_sent_width: got %b want 0", outs);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL stray_done_idle: got %b want 0", outs);
        end
    endtask

    task automatic test_simultaneous();
        int gaps; bit ok;
        ifrgap_cfg = 9'd2;
        txsend_req = 1'b1; txhrst_req = 1'b1; tick();
        txsend_req = 1'b0; txhrst_req = 1'b0;
        n_checks++;
        if ({msg_disc, tx_busy} !== 2'b10) begin
            n_fail++; $display("FAIL sim_disc: got %b want 10", {msg_disc, tx_busy});
        end
        tick();
        n_checks++;
        if ({msg_disc, tx_busy} !== 2'b01) begin
            n_fail++; $display("FAIL sim_disc_width: got %b want 01", {msg_disc, tx_busy});
        end
        wait_grant(gaps, ok);
        n_checks++;
        if (!ok || gaps != 2) begin
            n_fail++; $display("FAIL sim_gap_cycles: got %0d (ok=%0b) want 2", gaps, ok);
        end
        n_checks++;
        if ({transwin_en, transmit_en, tx_hrst} !== 3'b101) begin
            n_fail++; $display("FAIL sim_grant: got %b want 101", {transwin_en, transmit_en, tx_hrst});
        end
        tick();
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        n_checks++;
        if (outs !== 9'b001100010) begin
            n_fail++; $display("FAIL hrst_act_drop: got %b want 001100010", outs);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if (outs !== 9'b000001000) begin
            n_fail++; $display("FAIL hrst_sent: got %b want 000001000", outs);
        end
        tick();
    endtask

    task automatic test_collision();
        bit seen;
        ifrgap_cfg = 9'd4;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        seen = transwin_en;
        tick(); seen |= transwin_en;
        tick(); seen |= transwin_en;
        rx_active = 1'b1; rx_idle = 1'b0; tick();
        rx_active = 1'b0; rx_idle = 1'b1;
        n_checks++;
        if (outs !== 9'b000000100) begin
            n_fail++; $display("FAIL coll_disc: got %b want 000000100", outs);
        end
        repeat (10) begin
            tick();
            if (transwin_en || tx_busy || msg_disc) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL coll_no_window: got 1 want 0");
        end
    endtask

    task automatic test_abort();
        int gaps; bit ok;
        ifrgap_cfg = 9'd3;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        wait_grant(gaps, ok);
        tick(); tick();
        txhrst_req = 1'b1; tick(); txhrst_req = 1'b0;
        n_checks++;
        if ({transmit_en, tx_hrst, tx_busy} !== 3'b011) begin
            n_fail++; $display("FAIL abort_level: got %b want 011", {transmit_en, tx_hrst, tx_busy});
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if (outs !== 9'b000000100) begin
            n_fail++; $display("FAIL abort_disc: got %b want 000000100", outs);
        end
        wait_grant(gaps, ok);
        n_checks++;
        if (!ok || gaps != 4) begin
            n_fail++; $display("FAIL abort_gap_cycles: got %0d (ok=%0b) want 4", gaps, ok);
        end
        n_checks++;
        if ({transwin_en, transmit_en, tx_hrst} !== 3'b101) begin
            n_fail++; $display("FAIL abort_grant: got %b want 101", {transwin_en, transmit_en, tx_hrst});
        end
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        n_checks++;
        if (outs !== 9'b000001000) begin
            n_fail++; $display("FAIL abort_hrst_sent: got %b want 000001000", outs);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int gaps; int act; bit ok; bit hit; bit busy_seen;
        ifrgap_cfg = 9'd0;
        tmo_cfg = 16'd10;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        wait_grant(gaps, ok);
        n_checks++;
        if (!ok || gaps != 1) begin
            n_fail++; $display("FAIL gap0_cycles: got %0d (ok=%0b) want 1", gaps, ok);
        end
        act = 0; hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx_tmo) begin
                hit = 1'b1;
                break;
            end
            if (transmit_en) act++;
        end
        n_checks++;
        if (!hit || act != 10) begin
            n_fail++; $display("FAIL tmo_delay: got %0d (hit=%0b) want 10", act, hit);
        end
        n_checks++;
        if (outs !== 9'b000000001) begin
            n_fail++; $display("FAIL tmo_outs: got %b want 000000001", outs);
        end
        busy_seen = 1'b0;
        repeat (6) begin
            tick();
            if (tx_busy || tx_tmo) busy_seen = 1'b1;
        end
        n_checks++;
        if (busy_seen) begin
            n_fail++; $display("FAIL tmo_flags_clear: got busy/tmo 1 want 0");
        end
        tmo_cfg = 16'd0;
    endtask

    task automatic test_disable();
        int gaps; bit ok; bit busy_seen;
        ifrgap_cfg = 9'd1;
        txhrst_req = 1'b1; tick(); txhrst_req = 1'b0;
        wait_grant(gaps, ok);
        tick();
        n_checks++;
        if ({tx_hrst, tx_busy} !== 2'b11) begin
            n_fail++; $display("FAIL dis_act_hrst: got %b want 11", {tx_hrst, tx_busy});
        end
        ucpden = 1'b0; tick();
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL dis_clear: got %b want 0", outs);
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL dis_ignore: got %b want 0", outs);
        end
        ucpden = 1'b1;
        busy_seen = 1'b0;
        repeat (5) begin
            tick();
            if (outs !== 9'b0) busy_seen = 1'b1;
        end
        n_checks++;
        if (busy_seen) begin
            n_fail++; $display("FAIL dis_flags_clear: got activity want none");
        end
    endtask

    task automatic test_reset_in_gap();
        ifrgap_cfg = 9'd8;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        tick();
        n_checks++;
        if (tx_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_gap_busy: got %b want 1", tx_busy);
        end
        ic_rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL rst_async: got %b want 0", outs);
        end
        tick();
        ic_rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (outs !== 9'b0) begin
            n_fail++; $display("FAIL rst_flags_clear: got %b want 0", outs);
        end
    endtask

    initial begin
        test_reset();
        test_normal_msg();
        test_simultaneous();
        test_collision();
        test_abort();
        test_watchdog();
        test_disable();
        test_reset_in_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_ucpd_tx_sched.md
APB_UCPD_TX_SCHED -- requirements
Module: apb_ucpd_tx_sched

Interface
REQ-001 SHALL have parameter GAP_W, default 9, width of the interframe-gap counter and of ifrgap_cfg.
REQ-002 SHALL have parameter TMO_W, default 16, width of the watchdog counter and of tmo_cfg.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- ic_clk in 1: clock.
- ic_rst_n in 1: reset, asynchronous, active-low.
- ucpden in 1: peripheral enable; low = synchronous clear.
- txsend_req in 1: one-cycle SW request to send a message.
- txhrst_req in 1: one-cycle SW request to send a Hard Reset.
- rx_idle in 1: receiver idle, i.e. bus free.
- rx_active in 1: receiver detected a preamble.
- tx_done in 1: one-cycle pulse from the TX FSM when it returns to idle.
- ifrgap_cfg in GAP_W: interframe gap length, in ic_clk cycles.
- tmo_cfg in TMO_W: watchdog limit, in ic_clk cycles; 0 = watchdog disabled.
- transwin_en out 1: transmit window open, to the TX FSM.
- transmit_en out 1: message transmit level.
- tx_hrst out 1: hard-reset transmit level.
- tx_busy out 1: scheduler is not in IDLE.
- msg_sent out 1: one-cycle pulse, message transmission finished.
- hrst_sent out 1: one-cycle pulse, Hard Reset transmission finished.
- msg_disc out 1: one-cycle pulse, pending message discarded.
- req_drop out 1: one-cycle pulse, request ignored.
- tx_tmo out 1: one-cycle pulse, watchdog expired.

Function
REQ-004 SHALL hold pending flags msg_pend and hrst_pend.
- A set is caused by txsend_req or txhrst_req respectively.
- A flag is cleared only as stated in REQ-005 to REQ-013.
REQ-005 SHALL resolve simultaneous txsend_req and txhrst_req in favour of the Hard Reset.
- hrst_pend is set.
- msg_pend is not set.
- msg_disc pulses in the following cycle.
REQ-006 SHALL have the states IDLE, GAP, GRANT, ACT_MSG, ACT_HRST and the transitions below.
REQ-007 IDLE -> GAP when (msg_pend | hrst_pend) & ucpden; the gap counter is cleared on entry.
REQ-008 GAP behaviour:
- The counter increments each cycle while rx_idle=1 and clears to 0 in any cycle with rx_idle=0.
- GAP -> GRANT in the cycle where counter == ifrgap_cfg and rx_idle=1.
- With ifrgap_cfg=0, GRANT follows GAP after exactly one cycle.
- The counter saturates at its maximum value and does not wrap.
REQ-009 rx_active=1 in GAP with msg_pend=1 and hrst_pend=0:
- msg_pend is cleared.
- msg_disc pulses for one cycle.
- The next state is IDLE.
- A pending Hard Reset is never discarded.
REQ-010 GRANT lasts one cycle with transwin_en=1.
- With hrst_pend=1: tx_hrst=1 and the next state is ACT_HRST.
- Otherwise: transmit_en=1 and the next state is ACT_MSG.
REQ-011 ACT_MSG behaviour:
- transmit_en=1 is held.
- On tx_done: msg_sent pulses in the next cycle, msg_pend is cleared, and the next state is IDLE.
REQ-012 txhrst_req in ACT_MSG:
- Sets hrst_pend.
- Asserts tx_hrst=1 from the next cycle until tx_done, which aborts the message.
- On that tx_done: msg_disc pulses and msg_sent does not pulse, msg_pend is cleared, and the next state is IDLE.
- hrst_pend remains set, so a new GAP/GRANT sequence follows.
REQ-013 ACT_HRST behaviour:
- tx_hrst=1 is held.
- On tx_done: hrst_sent pulses, hrst_pend is cleared, and the next state is IDLE.
- txsend_req in ACT_HRST is ignored and pulses req_drop.
REQ-014 A request whose pending flag is already set SHALL be ignored and pulse req_drop.
- This includes txsend_req during ACT_MSG.
REQ-015 The watchdog counter SHALL count cycles spent in ACT_MSG/ACT_HRST and clear on leaving those states.
- With tmo_cfg != 0 and counter == tmo_cfg: tx_tmo pulses, both pending flags clear, and the next state is IDLE with no sent pulse.
REQ-016 transwin_en SHALL be asserted only in GRANT.
REQ-017 transmit_en and tx_hrst SHALL never both be 1 in the same cycle; tx_hrst wins.
REQ-018 tx_busy SHALL equal (state != IDLE).
REQ-019 All outputs SHALL be registered, and every pulse output SHALL be exactly one ic_clk cycle wide.
REQ-020 tx_done outside ACT_MSG/ACT_HRST SHALL be ignored.

Reset
REQ-021 While ic_rst_n=0, the following SHALL hold, asynchronously:
- State is IDLE.
- Both pending flags and both counters are 0.
- All outputs are 0.
REQ-022 ucpden=0 SHALL force the same values as REQ-021 on the next ic_clk edge, from any state, with no pulse outputs generated.
REQ-023 Requests arriving while ucpden=0 SHALL be ignored and SHALL NOT pulse req_drop.

Verification
REQ-024 Normal message:
- Stimulus: ifrgap_cfg=4, rx_idle=1, txsend_req pulse.
- Response: GAP for 5 cycles, then a GRANT cycle with transwin_en=1 and transmit_en=1.
- Stimulus: tx_done pulse after 20 cycles.
- Response: msg_sent pulse, then tx_busy=0.
REQ-025 Simultaneous requests:
- Stimulus: txsend_req and txhrst_req in the same cycle.
- Response: msg_disc pulse, GRANT with tx_hrst=1, transmit_en=0; hrst_sent after tx_done.
REQ-026 Collision:
- Stimulus: txsend_req, then rx_active=1 in the 2nd GAP cycle.
- Response: msg_disc pulse, return to IDLE, transwin_en never 1.
REQ-027 Abort:
- Stimulus: txhrst_req in ACT_MSG.
- Response: tx_hrst=1 next cycle, and msg_disc on tx_done.
- Response: a second GAP (ifrgap_cfg+1 cycles) and GRANT with tx_hrst=1; hrst_sent after the next tx_done.
REQ-028 Watchdog:
- Stimulus: tmo_cfg=10, no tx_done.
- Response: tx_tmo pulse 10 cycles after entering ACT_MSG, return to IDLE, pending flags 0.
REQ-029 Mid-operation reset/disable:
- Stimulus: ucpden=0 in ACT_HRST.
- Response: all outputs 0 next cycle; a later tx_done produces no pulse.
- Stimulus: ic_rst_n=0 in GAP.
- Response: immediate return to IDLE.
